// File: rtl/jam_param_if.sv
// Bus bundle for the job-assignment engine: run handshake, cost-memory
// read port and result outputs. The host drives Start/Mode and returns
// Cost one cycle after each W/J address. The engine drives everything else.
interface jam_param_if #(
  parameter int N    = 8,
  parameter int CW   = 8,
  parameter int CNTW = 16
);
  localparam int IW = $clog2(N);
  localparam int SW = CW + $clog2(N);

  logic              Start;
  logic              Mode;
  logic [IW-1:0]     W;
  logic [IW-1:0]     J;
  logic [CW-1:0]     Cost;
  logic              Busy;
  logic              Valid;
  logic [CNTW-1:0]   MatchCount;
  logic [SW-1:0]     MinCost;
  logic [N*IW-1:0]   BestPerm;

  // Host side: starts runs, serves the cost memory, collects results.
  modport master (
    output Start, Mode, Cost,
    input  W, J, Busy, Valid, MatchCount, MinCost, BestPerm
  );

  // Engine side.
  modport slave (
    input  Start, Mode, Cost,
    output W, J, Busy, Valid, MatchCount, MinCost, BestPerm
  );
endinterface

// File: rtl/jam_param.sv
// Exhaustive N x N job-assignment engine. It walks every permutation in
// lexicographic order. For each one it reads N costs from an external
// memory with one cycle of read latency and accumulates the total. It keeps
// the optimum (minimum or maximum), the number of permutations that reach
// it, and the first permutation that reached it.
// Cycle budget per permutation: N READ + 1 DRAIN + 1 UPDATE.
module jam_param #(
  parameter int N    = 8,
  parameter int CW   = 8,
  parameter int CNTW = 16
) (
  input  logic       CLK,
  input  logic       RST,
  jam_param_if.slave bus
);

  localparam int IW = $clog2(N);
  localparam int SW = CW + $clog2(N);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Field k of a permutation is the job given to worker k. Packed so that
  // field k sits at bits [k*IW +: IW], which is the BestPerm layout.
  typedef logic [N-1:0][IW-1:0] perm_t;

  function automatic perm_t identity_perm();
    perm_t p;
    for (int i = 0; i < N; i++) p[i] = IW'(i);
    return p;
  endfunction

  localparam perm_t IDENT = identity_perm();

  // Run state
  logic [2:0]       state_q, state_d;
  logic [IW-1:0]    k_q, k_d;
  logic [SW-1:0]    sum_q, sum_d;
  perm_t            perm_q, perm_d;
  logic             first_q, first_d;
  logic             mode_q, mode_d;

  // Best-so-far tracking
  logic [SW-1:0]    best_q, best_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  perm_t            bperm_q, bperm_d;

  // Registered outputs
  logic [IW-1:0]    w_q, w_d;
  logic [IW-1:0]    j_q, j_d;
  logic             valid_q, valid_d;
  logic [CNTW-1:0]  mcount_q, mcount_d;
  logic [SW-1:0]    mincost_q, mincost_d;
  perm_t            bpout_q, bpout_d;

  // Helpers
  logic [IW-1:0]    k_inc;
  perm_t            perm_nxt;
  logic             is_last;
  logic             take_new;

  assign k_inc = k_q + IW'(1);

  // Successor permutation in lexicographic order, and a flag for the last one
  always_comb begin : next_perm
    perm_t perm_sw;
    int    piv;
    int    swp;
    // NOTE: every signal driven here gets a value before any branch.
    // Otherwise a path that skips an assignment would infer a latch.
    perm_sw  = perm_q;
    perm_nxt = perm_q;
    is_last  = 1'b1;
    piv      = 0;
    swp      = 0;
    // Pivot: the rightmost ascent perm[i] < perm[i+1]. The later hit wins.
    for (int i = 0; i < N - 1; i++) begin
      if (perm_q[i] < perm_q[i+1]) begin
        piv     = i;
        is_last = 1'b0;
      end
    end
    // The rightmost element beyond the pivot that is larger than the pivot.
    for (int j = 0; j < N; j++) begin
      if (j > piv && perm_q[j] > perm_q[piv]) swp = j;
    end
    perm_sw[piv] = perm_q[swp];
    perm_sw[swp] = perm_q[piv];
    // The suffix after the pivot is descending. Reversing it gives the
    // smallest arrangement of that suffix.
    for (int t = 0; t < N; t++) begin
      if (t > piv) perm_nxt[t] = perm_sw[N + piv - t];
      else         perm_nxt[t] = perm_sw[t];
    end
  end

  // A completed sum replaces the best when it is the first sum or strictly better
  always_comb begin
    take_new = first_q || (mode_q ? (sum_q > best_q) : (sum_q < best_q));
  end

  // Next-state logic for the sequencer, the accumulator and the result registers
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    sum_d     = sum_q;
    perm_d    = perm_q;
    first_d   = first_q;
    mode_d    = mode_q;
    best_d    = best_q;
    cnt_d     = cnt_q;
    bperm_d   = bperm_q;
    w_d       = w_q;
    j_d       = j_q;
    valid_d   = 1'b0;
    mcount_d  = mcount_q;
    mincost_d = mincost_q;
    bpout_d   = bpout_q;

    case (state_q)
      S_IDLE: begin
        w_d = '0;
        j_d = '0;
        if (bus.Start) begin
          state_d = S_READ;
          perm_d  = IDENT;
          k_d     = '0;
          sum_d   = '0;
          first_d = 1'b1;
          mode_d  = bus.Mode;
          // The first address is issued so that it is on W/J in the first READ cycle.
          w_d     = '0;
          j_d     = IDENT[0];
        end
      end

      S_READ: begin
        // Cost in this cycle answers the address of the previous READ.
        if (k_q != '0) sum_d = sum_q + SW'(bus.Cost);
        if (k_q == IW'(N - 1)) begin
          state_d = S_DRAIN;
          w_d     = '0;
          j_d     = '0;
        end else begin
          k_d = k_inc;
          w_d = k_inc;
          j_d = perm_q[k_inc];
        end
      end

      S_DRAIN: begin
        // The last read (worker N-1) returns here.
        sum_d   = sum_q + SW'(bus.Cost);
        state_d = S_UPDATE;
      end

      S_UPDATE: begin
        if (take_new) begin
          best_d  = sum_q;
          cnt_d   = CNTW'(1);
          bperm_d = perm_q;
          first_d = 1'b0;
        end else if (sum_q == best_q) begin
          // A tie keeps the earlier permutation and counts up, saturating.
          if (cnt_q != '1) cnt_d = cnt_q + CNTW'(1);
        end
        if (is_last) begin
          state_d   = S_DONE;
          valid_d   = 1'b1;
          mcount_d  = cnt_d;
          mincost_d = best_d;
          bpout_d   = bperm_d;
          w_d       = '0;
          j_d       = '0;
        end else begin
          state_d = S_READ;
          perm_d  = perm_nxt;
          k_d     = '0;
          sum_d   = '0;
          w_d     = '0;
          j_d     = perm_nxt[0];
        end
      end

      S_DONE: begin
        // A Start in this cycle is dropped. Only IDLE accepts a Start.
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers. Reset clears everything, including earlier results.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      sum_q     <= '0;
      perm_q    <= '0;
      first_q   <= 1'b0;
      mode_q    <= 1'b0;
      best_q    <= '0;
      cnt_q     <= '0;
      bperm_q   <= '0;
      w_q       <= '0;
      j_q       <= '0;
      valid_q   <= 1'b0;
      mcount_q  <= '0;
      mincost_q <= '0;
      bpout_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register here sample
      // pre-edge values. This holds whatever order the statements are in.
      state_q   <= state_d;
      k_q       <= k_d;
      sum_q     <= sum_d;
      perm_q    <= perm_d;
      first_q   <= first_d;
      mode_q    <= mode_d;
      best_q    <= best_d;
      cnt_q     <= cnt_d;
      bperm_q   <= bperm_d;
      w_q       <= w_d;
      j_q       <= j_d;
      valid_q   <= valid_d;
      mcount_q  <= mcount_d;
      mincost_q <= mincost_d;
      bpout_q   <= bpout_d;
    end
  end

  assign bus.W          = w_q;
  assign bus.J          = j_q;
  assign bus.Busy       = (state_q != S_IDLE);
  assign bus.Valid      = valid_q;
  assign bus.MatchCount = mcount_q;
  assign bus.MinCost    = mincost_q;
  assign bus.BestPerm   = bpout_q;

endmodule

// File: tb/tb_jam_param.sv
// Bench for jam_param with three configurations: N=3, N=4 with a 4-bit
// counter, and N=5 with 4-bit costs. Each configuration has a
// one-cycle-latency cost memory that reads a shared matrix. The reference
// model brute-forces every N-digit base-N number in increasing order, keeps
// the ones with distinct digits and scores each of them.
module tb_jam_param;

  logic clk;
  logic rst;
  int   mat [8][8];

  int n_checks;
  int n_errors;

  jam_param_if #(.N(3), .CW(8), .CNTW(16)) if3 ();
  jam_param_if #(.N(4), .CW(8), .CNTW(4))  if4 ();
  jam_param_if #(.N(5), .CW(4), .CNTW(16)) if5 ();

  jam_param #(.N(3), .CW(8), .CNTW(16)) dut3 (.CLK(clk), .RST(rst), .bus(if3));
  jam_param #(.N(4), .CW(8), .CNTW(4))  dut4 (.CLK(clk), .RST(rst), .bus(if4));
  jam_param #(.N(5), .CW(4), .CNTW(16)) dut5 (.CLK(clk), .RST(rst), .bus(if5));

  logic        start_r [3];
  logic        mode_r  [3];
  logic        valid_a [3];
  logic        busy_a  [3];
  logic [63:0] cnt_a   [3];
  logic [63:0] cost_a  [3];
  logic [63:0] perm_a  [3];

  assign if3.Start = start_r[0];
  assign if4.Start = start_r[1];
  assign if5.Start = start_r[2];
  assign if3.Mode  = mode_r[0];
  assign if4.Mode  = mode_r[1];
  assign if5.Mode  = mode_r[2];

  assign valid_a[0] = if3.Valid;
  assign valid_a[1] = if4.Valid;
  assign valid_a[2] = if5.Valid;
  assign busy_a[0]  = if3.Busy;
  assign busy_a[1]  = if4.Busy;
  assign busy_a[2]  = if5.Busy;
  assign cnt_a[0]   = 64'(if3.MatchCount);
  assign cnt_a[1]   = 64'(if4.MatchCount);
  assign cnt_a[2]   = 64'(if5.MatchCount);
  assign cost_a[0]  = 64'(if3.MinCost);
  assign cost_a[1]  = 64'(if4.MinCost);
  assign cost_a[2]  = 64'(if5.MinCost);
  assign perm_a[0]  = 64'(if3.BestPerm);
  assign perm_a[1]  = 64'(if4.BestPerm);
  assign perm_a[2]  = 64'(if5.BestPerm);

  // Synchronous-read cost memories, one per engine.
  always @(posedge clk) begin
    if3.Cost <= 8'(mat[if3.W][if3.J]);
    if4.Cost <= 8'(mat[if4.W][if4.J]);
    if5.Cost <= 4'(mat[if5.W][if5.J]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int fact(input int n);
    int f = 1;
    for (int i = 2; i <= n; i++) f = f * i;
    return f;
  endfunction

  // Brute force over all assignments, in lexicographic order.
  task automatic ref_model(input int n, input int mode, input longint cnt_max, input int iw,
                           output longint best, output longint cnt, output longint bperm);
    int     d [8];
    int     code_max;
    int     tmp;
    int     used;
    bit     ok;
    bit     found;
    longint s;
    longint p;
    code_max = 1;
    for (int i = 0; i < n; i++) code_max = code_max * n;
    found = 1'b0;
    best  = 0;
    cnt   = 0;
    bperm = 0;
    for (int code = 0; code < code_max; code++) begin
      tmp = code;
      for (int pos = n - 1; pos >= 0; pos--) begin
        d[pos] = tmp % n;
        tmp    = tmp / n;
      end
      used = 0;
      ok   = 1'b1;
      s    = 0;
      p    = 0;
      for (int pos = 0; pos < n; pos++) begin
        if (used[d[pos]]) ok = 1'b0;
        used = used | (1 << d[pos]);
        s    = s + longint'(mat[pos][d[pos]]);
        p    = p | (longint'(d[pos]) << (pos * iw));
      end
      if (ok) begin
        if (!found || (mode != 0 ? s > best : s < best)) begin
          found = 1'b1;
          best  = s;
          cnt   = 1;
          bperm = p;
        end else if (s == best) begin
          cnt = cnt + 1;
        end
      end
    end
    if (cnt > cnt_max) cnt = cnt_max;
  endtask

  // One run, starting with Start high in the current cycle (cycle 0). A stray
  // Start is pulsed in cycle extra. On return the bench is in the cycle after Valid.
  task automatic run_test(input int id, input int n, input longint cnt_max, input int iw,
                          input int mode, input int extra, input string tag);
    longint eb, ec, ep;
    int     cyc;
    int     exp_cyc;
    ref_model(n, mode, cnt_max, iw, eb, ec, ep);
    exp_cyc = fact(n) * (n + 2) + 1;
    start_r[id] = 1'b1;
    mode_r[id]  = mode[0];
    @(negedge clk);
    cyc = 1;
    start_r[id] = 1'b0;
    mode_r[id]  = ~mode[0];
    check({tag, ".busy1"}, 64'(busy_a[id]), 64'd1);
    while (!valid_a[id] && cyc < exp_cyc + 20) begin
      @(negedge clk);
      cyc++;
      start_r[id] = (cyc == extra);
    end
    check({tag, ".valid_cycle"}, 64'(cyc), 64'(exp_cyc));
    check({tag, ".cost"}, cost_a[id], 64'(eb));
    check({tag, ".count"}, cnt_a[id], 64'(ec));
    check({tag, ".perm"}, perm_a[id], 64'(ep));
    @(negedge clk);
    start_r[id] = 1'b0;
    check({tag, ".valid_width"}, 64'(valid_a[id]), 64'd0);
    check({tag, ".busy_fall"}, 64'(busy_a[id]), 64'd0);
  endtask

  task automatic load_spec_matrix();
    int rows [3][3] = '{'{5, 1, 9}, '{2, 8, 3}, '{7, 4, 6}};
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        mat[i][j] = (i < 3 && j < 3) ? rows[i][j] : 0;
  endtask

  task automatic fill_matrix(input int lo, input int hi);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        mat[i][j] = int'($urandom_range(hi, lo));
  endtask

  initial begin : main
    int valid_seen;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 3; i++) begin
      start_r[i] = 1'b0;
      mode_r[i]  = 1'b0;
    end
    load_spec_matrix();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst.W", 64'(if3.W), 64'd0);
    check("rst.J", 64'(if3.J), 64'd0);
    check("rst.busy", 64'(if3.Busy), 64'd0);
    check("rst.valid", 64'(if3.Valid), 64'd0);
    check("rst.count", cnt_a[0], 64'd0);
    check("rst.cost", cost_a[0], 64'd0);
    check("rst.perm", perm_a[0], 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Matrix from the test plan. The stray Start at cycle 10 is ignored.
    run_test(0, 3, 64'hFFFF, 2, 0, 10, "n3_min");
    check("n3_min.const_cost", cost_a[0], 64'd9);
    check("n3_min.const_count", cnt_a[0], 64'd1);
    check("n3_min.const_perm", perm_a[0], 64'h21);
    // Back-to-back run, with a Start that coincides with DONE (ignored).
    run_test(0, 3, 64'hFFFF, 2, 0, 31, "n3_again");
    run_test(0, 3, 64'hFFFF, 2, 1, 0, "n3_max");
    check("n3_max.const_cost", cost_a[0], 64'd24);
    check("n3_max.const_count", cnt_a[0], 64'd1);
    check("n3_max.const_perm", perm_a[0], 64'h06);

    // All-equal costs with a 4-bit counter: 24 ties, saturating at 15.
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        mat[i][j] = 3;
    run_test(1, 4, 64'd15, 2, 0, 0, "n4_sat");
    check("n4_sat.const_cost", cost_a[1], 64'd12);
    check("n4_sat.const_count", cnt_a[1], 64'd15);
    check("n4_sat.const_perm", perm_a[1], 64'hE4);

    // Random matrices. Narrow value ranges force ties.
    for (int r = 0; r < 6; r++) begin
      fill_matrix(0, (r % 2 == 0) ? 255 : 2);
      run_test(0, 3, 64'hFFFF, 2, int'($urandom_range(1, 0)), 0, $sformatf("n3_rand%0d", r));
    end
    for (int r = 0; r < 4; r++) begin
      fill_matrix(0, (r % 2 == 0) ? 15 : 1);
      run_test(2, 5, 64'hFFFF, 3, int'($urandom_range(1, 0)), 0, $sformatf("n5_rand%0d", r));
    end

    // Reset in cycle 15 of a run: outputs clear immediately and no Valid follows.
    load_spec_matrix();
    start_r[0] = 1'b1;
    mode_r[0]  = 1'b0;
    @(negedge clk);
    start_r[0] = 1'b0;
    for (int c = 2; c <= 15; c++) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst.busy", 64'(if3.Busy), 64'd0);
    check("midrst.valid", 64'(if3.Valid), 64'd0);
    check("midrst.W", 64'(if3.W), 64'd0);
    check("midrst.J", 64'(if3.J), 64'd0);
    check("midrst.count", cnt_a[0], 64'd0);
    check("midrst.cost", cost_a[0], 64'd0);
    check("midrst.perm", perm_a[0], 64'd0);
    @(negedge clk);
    rst = 1'b0;
    valid_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (if3.Valid || if3.Busy) valid_seen++;
    end
    check("midrst.quiet", 64'(valid_seen), 64'd0);
    run_test(0, 3, 64'hFFFF, 2, 0, 0, "post_rst");
    check("post_rst.const_cost", cost_a[0], 64'd9);
    check("post_rst.const_perm", perm_a[0], 64'h21);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jam_param.md
# jam_param

Parametrised exhaustive job-assignment engine: for an N-worker × N-job cost matrix held in an external cost memory, it enumerates all N! assignments in lexicographic order and accumulates each total cost. It reports the optimum cost, how many assignments reach it, and the lexicographically first optimal assignment. It is the configurable successor of the fixed 8×8 JAM top. It adds selectable N, cost width, min/max mode, a Start/Busy handshake for repeated runs, and a BestPerm output.

## Interface
Parameters:
- N, 8, workers = jobs; legal range 2..8
- CW, 8, width of one Cost entry
- CNTW, 16, MatchCount width; count saturates at all-ones
- Derived: IW = $clog2(N); SW = CW + $clog2(N), the total-cost width

Ports:
- CLK  in  1  single clock, rising edge
- RST  in  1  asynchronous, active-high reset
- Start  in  1  one-cycle pulse that begins a run; sampled only in IDLE
- Mode  in  1  0 = minimise, 1 = maximise; latched at Start
- W  out  IW  worker index of the current cost read
- J  out  IW  job index of the current cost read
- Cost  in  CW  cost of (W,J) from the previous cycle; memory read latency is 1
- Busy  out  1  high from the cycle after Start is accepted through the DONE cycle
- Valid  out  1  one-cycle pulse when results are final
- MatchCount  out  CNTW  number of assignments achieving the optimum
- MinCost  out  SW  optimum total cost (the maximum when Mode=1)
- BestPerm  out  N*IW  field k = bits [k*IW +: IW] = job assigned to worker k

## Operation
- States: IDLE, READ, DRAIN, UPDATE, DONE.
- Registers:
  - perm[0..N-1], the current permutation
  - k, the read index, 0..N-1
  - sum (SW bits)
  - best, bestcnt, bestperm
  - first flag, mode_r
- IDLE:
  - W=J=0.
  - Start=1: perm=identity, k=0, sum=0, first=1, mode_r=Mode; go to READ.
- READ:
  - Drive W=k, J=perm[k].
  - If k>0, sum += Cost. That Cost belongs to read k-1.
  - When k=N-1, go to DRAIN; otherwise k++.
- DRAIN:
  - sum += Cost, the entry from read N-1.
  - W=J=0.
- UPDATE compares the completed sum against best:
  - Take the new sum as best when first=1, or sum<best (Mode 0), or sum>best (Mode 1). Then best=sum, bestcnt=1, bestperm=perm, first=0.
  - When sum==best and first=0: bestcnt++, saturating at 2^CNTW-1. bestperm is unchanged, so the lexicographically first optimum is retained.
  - If perm is fully descending (the last permutation), go to DONE.
  - Otherwise perm=next_permutation(perm), k=0, sum=0, go to READ.
- next_permutation is the standard algorithm, computed combinationally in the UPDATE cycle:
  1. Find the rightmost i with perm[i]<perm[i+1].
  2. Find the rightmost j>i with perm[j]>perm[i].
  3. Swap perm[i] and perm[j].
  4. Reverse perm[i+1..N-1].
- DONE:
  - Valid=1.
  - MatchCount, MinCost and BestPerm load from bestcnt, best and bestperm.
  - Next state is IDLE.
- Outputs hold their values until the next DONE or RST.
- Start outside IDLE is ignored, including Start coincident with DONE.
- Arithmetic:
  - sum is unsigned SW bits and never overflows: N·(2^CW−1) < 2^SW.
  - Cost is zero-extended before addition.

## Timing
- Reset values, applied asynchronously on RST:
  - state=IDLE.
  - W, J, Busy, Valid all 0.
  - MatchCount, MinCost, BestPerm all 0.
  - Internal registers all 0.
- RST mid-run aborts immediately. No Valid is produced, and the previous results are cleared to 0.
- Cycle numbering: Start is sampled at the edge ending cycle 0. Cycle 1 is the first READ, with Busy=1.
- Each permutation takes N+2 cycles: N READ, 1 DRAIN, 1 UPDATE.
- Valid is high in cycle N!·(N+2)+1. Busy falls in the cycle after that. Start is accepted again from that cycle.
  - N=3: Valid in cycle 31.
  - N=8: Valid in cycle 403201.
- Cost is sampled at the rising edge one cycle after the corresponding W/J was driven.
- W and J are registered outputs. They change only on clock edges, with no combinational path from Cost.

## Test plan
- N=3, CW=8, Mode=0. Matrix rows w0={5,1,9}, w1={2,8,3}, w2={7,4,6}. Expect:
  - MinCost=9, MatchCount=1, BestPerm=6'h21 (perm 1,0,2).
  - Valid exactly at cycle 31, 1 cycle wide.
- Same matrix, Mode=1. Expect MinCost=24, MatchCount=1, BestPerm=6'h06 (perm 2,1,0).
- N=8, every entry = 10. Expect:
  - MinCost=80, MatchCount=40320, BestPerm = identity (field k = k).
  - Valid at cycle 403201.
- N=4, CNTW=4, all entries equal 3. Expect:
  - MinCost=12.
  - MatchCount saturates at 15 (24 matches).
  - BestPerm = identity.
- Handshake:
  - Pulse Start again at cycle 10 of an N=3 run: ignored, run completes unchanged.
  - Start in the cycle after Valid: the second run gives identical results, with Valid 31 cycles later.
- Reset mid-run: assert RST at cycle 15 of an N=3 run.
  - All outputs go to 0 asynchronously, state returns to IDLE, and no Valid follows.
  - After release, a fresh Start yields the first test's results.
